// File: rtl/mmio_timer.sv
// Purpose : memory-mapped interval timer (CTRL/LOAD/COUNT/STATUS) with level irq.
// Latency : reads are combinational; writes and counting update on the next rising clk.
// Backpr. : none -- every bus access completes in the cycle it is presented.
//
// Ports:
//   clk, rstn        CPU clock, asynchronous active-low reset
//   addr, wdata      CPU data-bus address and write data (shared with data memory)
//   mem_w            write strobe, qualified internally by hit
//   rdata, hit       read data (0 when not hit) and window-hit flag for the top-level mux
//   irq              level interrupt = PEND & IE, driven from flops only
//
// Optional feature: define MMIO_TIMER_PRESCALE_EN to add the CTRL[8 +: PRESCALE_W]
// prescaler; without it the timer ticks every cycle and those CTRL bits read 0.
module mmio_timer #(
   parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
   parameter int          PRESCALE_W = 8
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        mem_w,
   output logic [31:0] rdata,
   output logic        hit,
   output logic        irq
);

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_LOAD   = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   // The prescale field must fit in CTRL above the three flag bits' byte.
   if (PRESCALE_W < 1 || PRESCALE_W > 24) begin : g_bad_prescale_w
      $error("mmio_timer: PRESCALE_W must be in 1..24");
   end

   logic        en_q, en_d;
   logic        reload_q, reload_d;
   logic        ie_q, ie_d;
   logic [31:0] load_q, load_d;
   logic [31:0] count_q, count_d;
   logic        pend_q, pend_d;

   logic        wr_en, wr_ctrl, wr_load, wr_count, wr_status;
   logic        en_rise, stop_wr, running, tick, expire;
   logic [31:0] psc_field;

   // ------------------------------------------------------------------
   // Bus decode
   // ------------------------------------------------------------------
   assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
   assign wr_en     = hit & mem_w;
   assign wr_ctrl   = wr_en & (addr[3:2] == REG_CTRL);
   assign wr_load   = wr_en & (addr[3:2] == REG_LOAD);
   assign wr_count  = wr_en & (addr[3:2] == REG_COUNT);
   assign wr_status = wr_en & (addr[3:2] == REG_STATUS);

   assign en_rise = wr_ctrl & wdata[0] & ~en_q;
   // A CTRL write clearing EN freezes COUNT this cycle, pre-empting any
   // decrement or one-shot expiry that would otherwise happen.
   assign stop_wr = wr_ctrl & ~wdata[0];
   assign running = en_q & (count_q != 32'd0) & ~stop_wr;
   assign expire  = running & tick & (count_q == 32'd1);

   // ------------------------------------------------------------------
   // Tick generation
   // ------------------------------------------------------------------
`ifdef MMIO_TIMER_PRESCALE_EN
   logic [PRESCALE_W-1:0] psc_q, psc_d;
   logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;

   assign tick      = (pcnt_q == psc_q);
   assign psc_field = 32'(psc_q) << 8;

   always_comb begin
      psc_d  = psc_q;
      pcnt_d = pcnt_q;
      if (wr_ctrl) begin
         psc_d = wdata[8 +: PRESCALE_W];
      end
      // Prescaler restarts on the enable edge so the first period is full.
      if (en_rise) begin
         pcnt_d = '0;
      end else if (en_q) begin
         pcnt_d = tick ? '0 : pcnt_q + PRESCALE_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         psc_q  <= '0;
         pcnt_q <= '0;
      end else begin
         psc_q  <= psc_d;
         pcnt_q <= pcnt_d;
      end
   end
`else
   assign tick      = 1'b1;
   assign psc_field = 32'h0;
`endif

   // ------------------------------------------------------------------
   // Register next-state. Later assignments carry higher priority:
   // bus writes beat counting, expiry beats the W1C clear.
   // ------------------------------------------------------------------
   always_comb begin
      en_d     = en_q;
      reload_d = reload_q;
      ie_d     = ie_q;
      load_d   = load_q;
      count_d  = count_q;
      pend_d   = pend_q;

      if (wr_load) begin
         load_d = wdata;
      end

      if (running && tick) begin
         if (count_q == 32'd1) begin
            if (reload_q) begin
               // load_d so a LOAD write in the same cycle takes effect.
               count_d = load_d;
            end else begin
               count_d = 32'd0;
               en_d    = 1'b0;
            end
         end else begin
            count_d = count_q - 32'd1;
         end
      end

      if (wr_ctrl) begin
         en_d     = wdata[0];
         reload_d = wdata[1];
         ie_d     = wdata[2];
      end

      if (en_rise) begin
         count_d = load_q;
      end

      if (wr_count) begin
         count_d = wdata;
      end

      if (wr_status && wdata[0]) begin
         pend_d = 1'b0;
      end
      if (expire) begin
         pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         en_q     <= 1'b0;
         reload_q <= 1'b0;
         ie_q     <= 1'b0;
         load_q   <= 32'h0;
         count_q  <= 32'h0;
         pend_q   <= 1'b0;
      end else begin
         en_q     <= en_d;
         reload_q <= reload_d;
         ie_q     <= ie_d;
         load_q   <= load_d;
         count_q  <= count_d;
         pend_q   <= pend_d;
      end
   end

   // ------------------------------------------------------------------
   // Read mux and interrupt
   // ------------------------------------------------------------------
   always_comb begin
      rdata = 32'h0;
      if (hit) begin
         unique case (addr[3:2])
            REG_CTRL:   rdata = psc_field | {29'h0, ie_q, reload_q, en_q};
            REG_LOAD:   rdata = load_q;
            REG_COUNT:  rdata = count_q;
            REG_STATUS: rdata = {31'h0, pend_q};
            default:    rdata = 32'h0;
         endcase
      end
   end

   assign irq = pend_q & ie_q;

   // Byte offset and unmapped CTRL/STATUS write bits are intentionally ignored.
   logic unused_bits;
   assign unused_bits = ^{addr[1:0], wdata};

endmodule

// File: tb/tb_mmio_timer.sv
// Purpose : directed self-checking bench for mmio_timer using an expected-value queue.
// Latency : one bus write per cycle; reads sampled combinationally mid low-phase.
// Backpr. : none.
module tb_mmio_timer;

   localparam logic [31:0] BASE   = 32'hFFFF_0000;
   localparam logic [31:0] A_CTRL = BASE + 32'h0;
   localparam logic [31:0] A_LOAD = BASE + 32'h4;
   localparam logic [31:0] A_CNT  = BASE + 32'h8;
   localparam logic [31:0] A_STAT = BASE + 32'hC;

   logic        clk;
   logic        rstn;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        mem_w;
   logic [31:0] rdata;
   logic        hit;
   logic        irq;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];
   string       tag_q[$];

   mmio_timer #(
      .BASE_ADDR (BASE),
      .PRESCALE_W(8)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .addr (addr),
      .wdata(wdata),
      .mem_w(mem_w),
      .rdata(rdata),
      .hit  (hit),
      .irq  (irq)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Expectation side of the scoreboard.
   task automatic expect_val(input logic [31:0] e, input string tag);
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   // Observation side: pop the oldest expectation and compare.
   task automatic observe(input logic [31:0] obs);
      logic [31:0] e;
      string       t;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_empty: observed %h expected <queued value>", obs);
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         checks++;
         assert (obs === e)
         else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", t, obs, e);
         end
      end
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] e, input string tag);
      expect_val(e, tag);
      addr  = a;
      mem_w = 1'b0;
      #1;
      observe(rdata);
   endtask

   task automatic chk_irq(input logic e, input string tag);
      expect_val({31'h0, e}, tag);
      #1;
      observe({31'h0, irq});
   endtask

   task automatic chk_hit(input logic [31:0] a, input logic e, input string tag);
      expect_val({31'h0, e}, tag);
      addr  = a;
      mem_w = 1'b0;
      #1;
      observe({31'h0, hit});
   endtask

   // Drive during the low phase; the write lands on the next rising edge.
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      mem_w = 1'b1;
      @(posedge clk);
      @(negedge clk);
      mem_w = 1'b0;
      addr  = 32'h0;
      wdata = 32'h0;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic seen_irq;
      rstn  = 1'b0;
      addr  = 32'h0;
      wdata = 32'h0;
      mem_w = 1'b0;
      #3;

      // ---------------- Reset state and decode ----------------
      chk_hit(A_CTRL, 1'b1, "hit_base");
      rd(A_CTRL, 32'h0, "rst_ctrl");
      chk_irq(1'b0, "rst_irq");
      @(negedge clk);
      rstn = 1'b1;

      wr(A_LOAD, 32'h0000_1234);
      rd(32'hFFFF_0006, 32'h0000_1234, "load_lowbits_ignored");
      rd(32'hFFFF_0010, 32'h0, "miss_rdata");
      chk_hit(32'hFFFF_0010, 1'b0, "miss_hit");
      wr(32'hFFFF_0018, 32'hDEAD_BEEF);       // non-hit write ignored
      rd(A_LOAD, 32'h0000_1234, "miss_write_ignored");

      // ---------------- Periodic mode ----------------
      wr(A_LOAD, 32'd5);
      wr(A_CTRL, 32'h7);                      // enable edge copies LOAD
      rd(A_CNT, 32'd5, "per_count_loaded");
      cyc(4);
      rd(A_CNT, 32'd1, "per_count_1");
      rd(A_STAT, 32'd0, "per_pend_not_yet");
      chk_irq(1'b0, "per_irq_not_yet");
      cyc(1);
      rd(A_STAT, 32'd1, "per_pend_set");
      rd(A_CNT, 32'd5, "per_reload");
      chk_irq(1'b1, "per_irq_set");
      wr(A_STAT, 32'h1);                      // W1C
      rd(A_STAT, 32'd0, "per_w1c");
      rd(A_CNT, 32'd4, "per_count_after_w1c");
      chk_irq(1'b0, "per_irq_cleared");
      cyc(3);
      rd(A_STAT, 32'd0, "per2_not_yet");
      cyc(1);
      rd(A_STAT, 32'd1, "per2_pend_set");

      // ---------------- Collisions ----------------
      cyc(4);
      rd(A_CNT, 32'd1, "col_count_1");
      wr(A_STAT, 32'h1);                      // W1C together with expiry
      rd(A_STAT, 32'd1, "col_expiry_beats_w1c");
      rd(A_CNT, 32'd5, "col_reload");
      wr(A_CNT, 32'd100);                     // write beats decrement
      rd(A_CNT, 32'd100, "col_count_write");
      cyc(1);
      rd(A_CNT, 32'd99, "col_decrement");
      wr(A_CTRL, 32'h7);                      // EN already 1: no reload
      rd(A_CNT, 32'd98, "no_reload_on_en_rewrite");
      wr(A_CTRL, 32'h0);                      // disable freezes COUNT
      rd(A_CTRL, 32'h0, "disable_ctrl");
      cyc(3);
      rd(A_CNT, 32'd98, "disable_count_holds");
      wr(A_STAT, 32'h0);                      // writing 0 has no effect
      rd(A_STAT, 32'd1, "w0_no_effect");
      wr(A_STAT, 32'h1);
      rd(A_STAT, 32'd0, "w1c_idle");

      // ---------------- One-shot mode ----------------
      wr(A_LOAD, 32'd3);
      wr(A_CTRL, 32'h5);
      cyc(2);
      rd(A_CNT, 32'd1, "os_count_1");
      chk_irq(1'b0, "os_irq_not_yet");
      cyc(1);
      chk_irq(1'b1, "os_irq_set");
      rd(A_CTRL, 32'h4, "os_en_cleared");
      rd(A_CNT, 32'd0, "os_count_zero");
      cyc(5);
      rd(A_CNT, 32'd0, "os_count_stays");
      chk_irq(1'b1, "os_irq_level");
      wr(A_STAT, 32'h1);
      chk_irq(1'b0, "os_irq_cleared");

      // ---------------- Zero load ----------------
      wr(A_CTRL, 32'h0);
      wr(A_LOAD, 32'd0);
      wr(A_CTRL, 32'h7);
      seen_irq = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         #1;
         if (irq !== 1'b0) seen_irq = 1'b1;
      end
      expect_val(32'd0, "zero_load_no_irq");
      observe({31'h0, seen_irq});
      rd(A_CNT, 32'd0, "zero_load_count");

      // ---------------- Reset mid-run ----------------
      wr(A_CTRL, 32'h0);
      wr(A_LOAD, 32'd2);
      wr(A_CTRL, 32'h7);
      cyc(2);
      chk_irq(1'b1, "pre_reset_irq");
      rstn = 1'b0;
      chk_irq(1'b0, "reset_irq");
      rd(A_CTRL, 32'h0, "reset_ctrl");
      rd(A_LOAD, 32'h0, "reset_load");
      rd(A_CNT, 32'h0, "reset_count");
      rd(A_STAT, 32'h0, "reset_status");
      @(negedge clk);
      rstn = 1'b1;

      // ---------------- Prescaler ----------------
`ifdef MMIO_TIMER_PRESCALE_EN
      wr(A_LOAD, 32'd2);
      wr(A_CTRL, 32'h0000_0307);
      rd(A_CTRL, 32'h0000_0307, "psc_ctrl_readback");
      cyc(7);
      rd(A_STAT, 32'd0, "psc_not_yet");
      cyc(1);
      rd(A_STAT, 32'd1, "psc_pend_at_8");
`else
      wr(A_CTRL, 32'h0000_0307);
      rd(A_CTRL, 32'h0000_0007, "no_psc_ctrl_readback");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
